// File: rtl/cpu_bus_arbiter_if.sv
// Bundle of fetch-port, data-port and system-bus signals around cpu_bus_arbiter.
// The master modport is the arbiter's view; slave is the view of the surrounding CPU and bus.
interface cpu_bus_arbiter_if;
   logic        i_fetch_request;
   logic        o_fetch_ready;
   logic [31:0] i_fetch_address;
   logic [31:0] o_fetch_rdata;
   logic        i_data_request;
   logic        i_data_rw;
   logic        o_data_ready;
   logic [31:0] i_data_address;
   logic [31:0] i_data_wdata;
   logic [31:0] o_data_rdata;
   logic        o_bus_request;
   logic        o_bus_rw;
   logic        i_bus_ready;
   logic [31:0] o_bus_address;
   logic [31:0] o_bus_wdata;
   logic [31:0] i_bus_rdata;
   logic        o_bus_error;

   modport master (
      input  i_fetch_request, i_fetch_address,
      input  i_data_request, i_data_rw, i_data_address, i_data_wdata,
      input  i_bus_ready, i_bus_rdata,
      output o_fetch_ready, o_fetch_rdata, o_data_ready, o_data_rdata,
      output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_bus_error
   );

   modport slave (
      output i_fetch_request, i_fetch_address,
      output i_data_request, i_data_rw, i_data_address, i_data_wdata,
      output i_bus_ready, i_bus_rdata,
      input  o_fetch_ready, o_fetch_rdata, o_data_ready, o_data_rdata,
      input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_bus_error
   );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Shares one memory bus between the instruction-fetch port and the load/store data port.
// Optional transfer watchdog enabled by defining CPU_BUS_ARBITER_TIMEOUT_EN.
module cpu_bus_arbiter #(
   parameter int DATA_PRIORITY  = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic               i_clock,
   input logic               i_reset,
   cpu_bus_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
   typedef enum logic {OWNER_FETCH, OWNER_DATA} owner_t;

   state_t state;
   owner_t last_owner;

   logic        owner_request;
   logic        timeout;
   logic        resp_ready;
   logic [31:0] resp_data;

   assign owner_request = (state == FETCH) ? bus.i_fetch_request :
                          (state == DATA)  ? bus.i_data_request  : 1'b0;

`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
   logic [7:0] wait_count;

   // Granted cycle k holds wait_count == k-1, so the limit fires on cycle TIMEOUT_CYCLES.
   assign timeout = owner_request && !bus.i_bus_ready &&
                    (wait_count == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)
         wait_count <= 8'd0;
      else if (state == IDLE)
         wait_count <= 8'd0;
      else if (!bus.i_bus_ready)
         wait_count <= wait_count + 8'd1;
   end
`else
   // Without the watchdog a stalled transfer waits forever.
   assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

   assign resp_ready = bus.i_bus_ready | timeout;
   assign resp_data  = timeout ? 32'hDEAD_BEEF : bus.i_bus_rdata;

   assign bus.o_bus_request = owner_request;
   assign bus.o_bus_rw      = (state == DATA) & bus.i_data_rw;
   assign bus.o_bus_address = (state == FETCH) ? bus.i_fetch_address :
                              (state == DATA)  ? bus.i_data_address  : 32'd0;
   assign bus.o_bus_wdata   = (state == DATA) ? bus.i_data_wdata : 32'd0;
   assign bus.o_bus_error   = timeout;

   assign bus.o_fetch_ready = (state == FETCH) & resp_ready;
   assign bus.o_fetch_rdata = (state == FETCH) ? resp_data : 32'd0;
   assign bus.o_data_ready  = (state == DATA) & resp_ready;
   assign bus.o_data_rdata  = (state == DATA) ? resp_data : 32'd0;

   // A dropped request aborts without touching last_owner; only completions rotate fairness.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state      <= IDLE;
         last_owner <= OWNER_FETCH;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_fetch_request && bus.i_data_request)
                  state <= ((DATA_PRIORITY != 0) || (last_owner == OWNER_FETCH)) ? DATA : FETCH;
               else if (bus.i_fetch_request)
                  state <= FETCH;
               else if (bus.i_data_request)
                  state <= DATA;
            end
            FETCH: begin
               if (!bus.i_fetch_request)
                  state <= IDLE;
               else if (resp_ready) begin
                  state      <= IDLE;
                  last_owner <= OWNER_FETCH;
               end
            end
            DATA: begin
               if (!bus.i_data_request)
                  state <= IDLE;
               else if (resp_ready) begin
                  state      <= IDLE;
                  last_owner <= OWNER_DATA;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: a fixed-priority instance and a round-robin instance.
// Honours CPU_BUS_ARBITER_TIMEOUT_EN when the same macro is defined for the bench.
module tb_cpu_bus_arbiter;

   logic clock;
   logic reset_n;
   int   checks;
   int   errors;

   cpu_bus_arbiter_if if_a ();
   cpu_bus_arbiter_if if_b ();

   cpu_bus_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(8)) dut_a (
      .i_clock (clock),
      .i_reset (reset_n),
      .bus     (if_a)
   );

   cpu_bus_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(8)) dut_b (
      .i_clock (clock),
      .i_reset (reset_n),
      .bus     (if_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic fetch_req, input logic [31:0] fetch_addr,
                                input logic data_req, input logic data_rw,
                                input logic [31:0] data_addr, input logic [31:0] wdata,
                                input logic bus_ready, input logic [31:0] bus_rdata);
      if_a.i_fetch_request = fetch_req;
      if_a.i_fetch_address = fetch_addr;
      if_a.i_data_request  = data_req;
      if_a.i_data_rw       = data_rw;
      if_a.i_data_address  = data_addr;
      if_a.i_data_wdata    = wdata;
      if_a.i_bus_ready     = bus_ready;
      if_a.i_bus_rdata     = bus_rdata;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   logic [31:0] rr_addr  [8];
   logic        rr_fready[8];
   logic        rr_dready[8];

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      if_b.i_fetch_request = 1'b0;
      if_b.i_fetch_address = 32'h0;
      if_b.i_data_request  = 1'b0;
      if_b.i_data_rw       = 1'b0;
      if_b.i_data_address  = 32'h0;
      if_b.i_data_wdata    = 32'h0;
      if_b.i_bus_ready     = 1'b0;
      if_b.i_bus_rdata     = 32'h0;
      rr_addr   = '{32'h600, 32'h0, 32'h500, 32'h0, 32'h600, 32'h0, 32'h500, 32'h0};
      rr_fready = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      rr_dready = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      // Reset state, with bus ready and data driven to show nothing leaks through
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h55);
      tick(); #1;
      checkOutput("rst_bus_request", 32'(if_a.o_bus_request), 32'h0);
      checkOutput("rst_bus_rw",      32'(if_a.o_bus_rw),      32'h0);
      checkOutput("rst_bus_address", if_a.o_bus_address,      32'h0);
      checkOutput("rst_bus_wdata",   if_a.o_bus_wdata,        32'h0);
      checkOutput("rst_fetch_ready", 32'(if_a.o_fetch_ready), 32'h0);
      checkOutput("rst_fetch_rdata", if_a.o_fetch_rdata,      32'h0);
      checkOutput("rst_data_ready",  32'(if_a.o_data_ready),  32'h0);
      checkOutput("rst_data_rdata",  if_a.o_data_rdata,       32'h0);
      checkOutput("rst_bus_error",   32'(if_a.o_bus_error),   32'h0);
      tick();
      reset_n = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // Fetch alone at 0x100, bus ready on the third granted cycle
      tick();
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      checkOutput("f1_arb_latency", 32'(if_a.o_bus_request), 32'h0);
      tick(); #1;
      checkOutput("f1_bus_request", 32'(if_a.o_bus_request), 32'h1);
      checkOutput("f1_bus_address", if_a.o_bus_address,      32'h100);
      checkOutput("f1_bus_rw",      32'(if_a.o_bus_rw),      32'h0);
      checkOutput("f1_wait1_ready", 32'(if_a.o_fetch_ready), 32'h0);
      tick(); #1;
      checkOutput("f1_wait2_ready", 32'(if_a.o_fetch_ready), 32'h0);
      tick();
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h13);
      #1;
      checkOutput("f1_fetch_ready", 32'(if_a.o_fetch_ready), 32'h1);
      checkOutput("f1_fetch_rdata", if_a.o_fetch_rdata,      32'h13);
      checkOutput("f1_data_ready",  32'(if_a.o_data_ready),  32'h0);
      checkOutput("f1_data_rdata",  if_a.o_data_rdata,       32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h99);
      #1;
      checkOutput("f1_idle_request",     32'(if_a.o_bus_request), 32'h0);
      checkOutput("f1_idle_ready_ignore", 32'(if_a.o_fetch_ready), 32'h0);
      checkOutput("f1_idle_rdata",       if_a.o_fetch_rdata,      32'h0);

      // Simultaneous requests: data write wins, one idle cycle, then fetch
      tick();
      applyStimulus(1'b1, 32'h104, 1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 1'b1, 32'hAAAA5555);
      #1;
      checkOutput("p_idle_request", 32'(if_a.o_bus_request), 32'h0);
      tick(); #1;
      checkOutput("p_data_request", 32'(if_a.o_bus_request), 32'h1);
      checkOutput("p_data_rw",      32'(if_a.o_bus_rw),      32'h1);
      checkOutput("p_data_address", if_a.o_bus_address,      32'h2000);
      checkOutput("p_data_wdata",   if_a.o_bus_wdata,        32'hCAFEF00D);
      checkOutput("p_data_ready",   32'(if_a.o_data_ready),  32'h1);
      checkOutput("p_fetch_blocked", 32'(if_a.o_fetch_ready), 32'h0);
      tick();
      applyStimulus(1'b1, 32'h104, 1'b0, 1'b1, 32'h2000, 32'hCAFEF00D, 1'b1, 32'hAAAA5555);
      #1;
      checkOutput("p_gap_request", 32'(if_a.o_bus_request), 32'h0);
      tick(); #1;
      checkOutput("p_fetch_address", if_a.o_bus_address,      32'h104);
      checkOutput("p_fetch_rw",      32'(if_a.o_bus_rw),      32'h0);
      checkOutput("p_fetch_wdata",   if_a.o_bus_wdata,        32'h0);
      checkOutput("p_fetch_ready",   32'(if_a.o_fetch_ready), 32'h1);
      checkOutput("p_fetch_rdata",   if_a.o_fetch_rdata,      32'hAAAA5555);
      checkOutput("p_data_rdata",    if_a.o_data_rdata,       32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // Data read aborted by dropping the request before ready
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, 32'h0);
      tick(); #1;
      checkOutput("ab_bus_request", 32'(if_a.o_bus_request), 32'h1);
      checkOutput("ab_bus_address", if_a.o_bus_address,      32'h3000);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h3000, 32'h0, 1'b0, 32'h0);
      #1;
      checkOutput("ab_request_fall", 32'(if_a.o_bus_request), 32'h0);
      checkOutput("ab_no_ready",     32'(if_a.o_data_ready),  32'h0);
      tick();
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      checkOutput("ab_idle_after", 32'(if_a.o_bus_request), 32'h0);
      tick(); #1;
      checkOutput("ab_next_grant", if_a.o_bus_address, 32'h300);
      tick();
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h31);
      #1;
      checkOutput("ab_next_ready", 32'(if_a.o_fetch_ready), 32'h1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // Reset during a data grant clears every output immediately
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h4000, 32'h12345678, 1'b0, 32'h0);
      tick(); #1;
      checkOutput("rs_granted", if_a.o_bus_wdata, 32'h12345678);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h4000, 32'h12345678, 1'b1, 32'hBEEF);
      reset_n = 1'b0;
      #1;
      checkOutput("rs_bus_request", 32'(if_a.o_bus_request), 32'h0);
      checkOutput("rs_bus_rw",      32'(if_a.o_bus_rw),      32'h0);
      checkOutput("rs_bus_address", if_a.o_bus_address,      32'h0);
      checkOutput("rs_bus_wdata",   if_a.o_bus_wdata,        32'h0);
      checkOutput("rs_data_ready",  32'(if_a.o_data_ready),  32'h0);
      checkOutput("rs_data_rdata",  if_a.o_data_rdata,       32'h0);
      tick();
      reset_n = 1'b1;
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      checkOutput("rs_post_idle", 32'(if_a.o_bus_request), 32'h0);
      tick();
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77);
      #1;
      checkOutput("rs_post_address", if_a.o_bus_address,      32'h200);
      checkOutput("rs_post_ready",   32'(if_a.o_fetch_ready), 32'h1);
      checkOutput("rs_post_rdata",   if_a.o_fetch_rdata,      32'h77);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // Round-robin instance: last_owner starts at FETCH, so DATA wins the first tie
      tick();
      if_b.i_fetch_request = 1'b1;
      if_b.i_fetch_address = 32'h500;
      if_b.i_data_request  = 1'b1;
      if_b.i_data_address  = 32'h600;
      if_b.i_bus_ready     = 1'b1;
      if_b.i_bus_rdata     = 32'h5A;
      #1;
      checkOutput("rr_idle_request", 32'(if_b.o_bus_request), 32'h0);
      for (int i = 0; i < 8; i++) begin
         tick(); #1;
         checkOutput($sformatf("rr_address_%0d", i), if_b.o_bus_address,      rr_addr[i]);
         checkOutput($sformatf("rr_fready_%0d", i),  32'(if_b.o_fetch_ready), 32'(rr_fready[i]));
         checkOutput($sformatf("rr_dready_%0d", i),  32'(if_b.o_data_ready),  32'(rr_dready[i]));
      end
      if_b.i_fetch_request = 1'b0;
      if_b.i_data_request  = 1'b0;
      if_b.i_bus_ready     = 1'b0;

      // Stalled fetch: watchdog fires on granted cycle 8, or waits indefinitely without it
      tick();
      applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
      for (int k = 1; k < 8; k++) begin
         tick(); #1;
         checkOutput($sformatf("to_error_c%0d", k), 32'(if_a.o_bus_error),   32'h0);
         checkOutput($sformatf("to_ready_c%0d", k), 32'(if_a.o_fetch_ready), 32'h0);
      end
      tick(); #1;
      checkOutput("to_error_c8", 32'(if_a.o_bus_error),   32'h1);
      checkOutput("to_ready_c8", 32'(if_a.o_fetch_ready), 32'h1);
      checkOutput("to_rdata_c8", if_a.o_fetch_rdata,      32'hDEADBEEF);
      tick(); #1;
      checkOutput("to_idle_after", 32'(if_a.o_bus_request), 32'h0);
`else
      for (int k = 1; k <= 12; k++) begin
         tick(); #1;
         checkOutput($sformatf("stall_error_c%0d", k),   32'(if_a.o_bus_error),   32'h0);
         checkOutput($sformatf("stall_request_c%0d", k), 32'(if_a.o_bus_request), 32'h1);
         checkOutput($sformatf("stall_ready_c%0d", k),   32'(if_a.o_fetch_ready), 32'h0);
      end
`endif
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      checkOutput("end_request", 32'(if_a.o_bus_request), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
